// File: rtl/serial_buff_ctrl.sv
// Purpose: sequences one serial_buff: shift an NDATA-bit frame, load it, hand it out a nibble at a time.
// Latency: first nib_valid NDATA bit_valid cycles + 2 after start; one nibble every 2 cycles unstalled.
// Backpressure: nib_valid holds with stable data while nib_ready is low; build option SBC_TIMEOUT_EN adds a SHIFT idle timeout.
module serial_buff_ctrl #(
    parameter int NDATA   = 128,
    parameter int MOVIN   = 0,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_start,
    input  logic                         i_bit_valid,
    output logic                         o_sb_ena,
    output logic [$clog2(NDATA)-1:0]     o_sb_cntin,
    output logic                         o_nib_valid,
    input  logic                         i_nib_ready,
    output logic [$clog2(NDATA/4)-1:0]   o_nib_idx,
    output logic                         o_busy,
    output logic                         o_done,
    output logic                         o_err
);

    localparam int CW   = $clog2(NDATA);
    localparam int IW   = $clog2(NDATA/4);
    localparam int BW   = CW + 1;
    localparam int NNIB = NDATA / 4;

    localparam logic [IW-1:0] LAST_IDX = IW'(NNIB - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(NDATA - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SHIFT   = 3'd1;
    localparam logic [2:0] S_LOAD    = 3'd2;
    localparam logic [2:0] S_PRESENT = 3'd3;
    localparam logic [2:0] S_ROTATE  = 3'd4;

    logic [2:0]    r_state, w_nxt_state;
    logic [BW-1:0] r_bits, w_nxt_bits;
    logic [IW-1:0] r_idx, w_nxt_idx, w_r_idx_inc, w_nxt_idx_inc;
    logic [CW-1:0] r_cntin, w_nxt_cntin;
    logic          r_nib_valid, r_busy, r_done, w_nxt_done;

`ifdef SBC_TIMEOUT_EN
    localparam int GW = $clog2(TIMEOUT + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT - 1);

    logic [GW-1:0] r_gap, w_nxt_gap;
    logic          r_err, w_nxt_err;
`endif

    assign w_r_idx_inc   = r_idx + IW'(1);
    assign w_nxt_idx_inc = w_nxt_idx + IW'(1);

    // Next-state, counter and done-pulse decode
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_bits  = r_bits;
        w_nxt_idx   = r_idx;
        w_nxt_done  = 1'b0;
`ifdef SBC_TIMEOUT_EN
        w_nxt_gap   = r_gap;
        w_nxt_err   = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                // the done cycle is already IDLE but must not accept a new frame
                if (i_start && !r_done) begin
                    w_nxt_state = S_SHIFT;
                    w_nxt_bits  = '0;
`ifdef SBC_TIMEOUT_EN
                    w_nxt_gap   = '0;
`endif
                end
            end
            S_SHIFT: begin
                if (i_bit_valid) begin
                    w_nxt_bits = r_bits + BW'(1);
                    if (r_bits == LAST_BIT) begin
                        w_nxt_state = S_LOAD;
                    end
`ifdef SBC_TIMEOUT_EN
                    w_nxt_gap = '0;
                end else if (r_gap == GAP_LAST) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_nxt_gap = r_gap + GW'(1);
`endif
                end
            end
            S_LOAD: begin
                w_nxt_state = S_PRESENT;
                w_nxt_idx   = '0;
            end
            S_PRESENT: begin
                if (i_nib_ready) begin
                    if ((MOVIN != 0) || (r_idx == LAST_IDX)) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_done  = 1'b1;
                    end else begin
                        w_nxt_state = S_ROTATE;
                    end
                end
            end
            S_ROTATE: begin
                w_nxt_idx   = w_r_idx_inc;
                w_nxt_state = S_PRESENT;
            end
            default: begin
                w_nxt_state = S_IDLE;
            end
        endcase
    end

    // serial_buff command for the coming state: 0 loads, xx01 holds, nonzero xx00 rotates one nibble
    always_comb begin
        w_nxt_cntin = CW'(1);
        case (w_nxt_state)
            S_LOAD:    w_nxt_cntin = '0;
            S_PRESENT: w_nxt_cntin = {w_nxt_idx, 2'b01};
            S_ROTATE:  w_nxt_cntin = {w_nxt_idx_inc, 2'b00};
            default:   w_nxt_cntin = CW'(1);
        endcase
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_bits      <= '0;
            r_idx       <= '0;
            r_cntin     <= CW'(1);
            r_nib_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state     <= w_nxt_state;
            r_bits      <= w_nxt_bits;
            r_idx       <= w_nxt_idx;
            r_cntin     <= w_nxt_cntin;
            r_nib_valid <= (w_nxt_state == S_PRESENT);
            r_busy      <= (w_nxt_state != S_IDLE);
            r_done      <= w_nxt_done;
        end
    end

`ifdef SBC_TIMEOUT_EN
    // Idle-gap counter and timeout pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_gap <= '0;
            r_err <= 1'b0;
        end else begin
            r_gap <= w_nxt_gap;
            r_err <= w_nxt_err;
        end
    end

    assign o_err = r_err;
`else
    // no gap counter in this build; the comparison is constant false
    assign o_err = (TIMEOUT < 0);
`endif

    assign o_sb_ena    = (r_state == S_SHIFT) & i_bit_valid;
    assign o_sb_cntin  = r_cntin;
    assign o_nib_valid = r_nib_valid;
    assign o_nib_idx   = r_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

endmodule

// File: tb/tb_serial_buff_ctrl.sv
// Purpose: directed check of serial_buff_ctrl at NDATA=16 against a behavioural serial_buff model.
// Latency: frames are driven cycle by cycle; every PRESENT/ROTATE/done cycle is checked at a fixed slot.
// Backpressure: nib_ready stalls are taken from the vector table.
module tb_serial_buff_ctrl;

    typedef struct {
        logic [15:0] data;
        int          gap;
        int          st_idx;
        int          st_len;
        bit          noise;
        logic [15:0] exp_nibs;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic       bit_valid = 1'b0;
    logic       din = 1'b0;
    logic       nib_ready = 1'b0;

    logic       sb_ena, nib_valid, busy, done, err;
    logic [3:0] sb_cntin;
    logic [1:0] nib_idx;

    logic       sb_ena_w, nib_valid_w, busy_w, done_w, err_w;
    logic [3:0] sb_cntin_w;
    logic [1:0] nib_idx_w;

    logic [15:0] m_sr = '0;
    logic [15:0] m_dout = '0;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_buff_ctrl #(.NDATA(16), .MOVIN(0), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .i_start(start), .i_bit_valid(bit_valid),
        .o_sb_ena(sb_ena), .o_sb_cntin(sb_cntin), .o_nib_valid(nib_valid),
        .i_nib_ready(nib_ready), .o_nib_idx(nib_idx), .o_busy(busy),
        .o_done(done), .o_err(err)
    );

    serial_buff_ctrl #(.NDATA(16), .MOVIN(1), .TIMEOUT(8)) dut_w (
        .clk(clk), .rst(rst), .i_start(start), .i_bit_valid(bit_valid),
        .o_sb_ena(sb_ena_w), .o_sb_cntin(sb_cntin_w), .o_nib_valid(nib_valid_w),
        .i_nib_ready(nib_ready), .o_nib_idx(nib_idx_w), .o_busy(busy_w),
        .o_done(done_w), .o_err(err_w)
    );

    // serial_buff model: shift MSB first on ena, load on cntin 0, rotate one nibble on nonzero xx00
    always @(posedge clk) begin
        if (sb_ena) m_sr <= {m_sr[14:0], din};
        if (sb_cntin == 4'd0) m_dout <= m_sr;
        else if (sb_cntin[1:0] == 2'b00) m_dout <= {m_dout[11:0], m_dout[15:12]};
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_rst();
        chk("rst_ena", sb_ena, 0);
        chk("rst_cntin", sb_cntin, 1);
        chk("rst_valid", nib_valid, 0);
        chk("rst_idx", nib_idx, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
    endtask

    // start pulse, then shift 16 bits (one every 'gap' cycles), then the LOAD cycle
    task automatic send_bits(input logic [15:0] data, input int gap, input bit noise);
        int   bits = 0;
        int   cyc = 0;
        logic bv;
        @(posedge clk); #1;
        start = 1'b1;
        bit_valid = 1'b0;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        @(posedge clk); #1;
        start = 1'b0;
        while (bits < 16 && cyc < 100) begin
            bv = ((cyc % gap) == gap - 1);
            bit_valid = bv;
            din = data[15 - bits];
            start = noise && (cyc == 3);
            @(negedge clk);
            chk("shift_ena", sb_ena, bv);
            chk("shift_busy", busy, 1);
            chk("shift_cntin", sb_cntin, 1);
            chk("shift_valid", nib_valid, 0);
            @(posedge clk); #1;
            if (bv) bits++;
            cyc++;
        end
        start = 1'b0;
        bit_valid = 1'b1;
        @(negedge clk);
        chk("load_cntin", sb_cntin, 0);
        chk("load_valid", nib_valid, 0);
        chk("load_ena", sb_ena, 0);
        @(posedge clk); #1;
        bit_valid = 1'b0;
    endtask

    // PRESENT/ROTATE sequence; returns while presenting nibble stop_at when stop_at >= 0
    task automatic present(input logic [15:0] exp_nibs, input int st_idx, input int st_len,
                           input bit noise, input bit chk_w, input int stop_at);
        for (int k = 0; k < 4; k++) begin
            int stl;
            stl = (k == st_idx) ? st_len : 0;
            for (int s = 0; s <= stl; s++) begin
                nib_ready = (s == stl);
                start = noise && (s == 0);
                @(negedge clk);
                chk("pres_valid", nib_valid, 1);
                chk("pres_idx", nib_idx, k);
                chk("pres_cntin", sb_cntin, 4 * k + 1);
                chk("pres_nibble", m_dout[15:12], exp_nibs[15 - 4 * k -: 4]);
                if (chk_w && k == 0) begin
                    chk("word_valid", nib_valid_w, 1);
                    chk("word_cntin", sb_cntin_w, 1);
                end
                if (k == stop_at) return;
                @(posedge clk); #1;
            end
            start = 1'b0;
            if (k < 3) begin
                @(negedge clk);
                chk("rot_valid", nib_valid, 0);
                chk("rot_cntin", sb_cntin, 4 * k + 4);
                chk("rot_idx", nib_idx, k);
                if (chk_w && k == 0) begin
                    chk("word_done", done_w, 1);
                    chk("word_busy", busy_w, 0);
                end
                @(posedge clk); #1;
            end
        end
        nib_ready = 1'b0;
    endtask

    // done pulse right after the last transfer; a start on that cycle must be ignored
    task automatic finish_frame(input bit noise);
        start = noise;
        @(negedge clk);
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_cntin", sb_cntin, 1);
        chk("done_valid", nib_valid, 0);
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("done_clear", done, 0);
        chk("post_busy", busy, 0);
    endtask

    initial begin
        vec_t tbl[4];
        tbl[0] = '{16'hA5C3, 1, -1, 0, 1'b0, 16'hA5C3};
        tbl[1] = '{16'hA5C3, 1,  1, 5, 1'b0, 16'hA5C3};
        tbl[2] = '{16'h3C96, 3, -1, 0, 1'b0, 16'h3C96};
        tbl[3] = '{16'h0FF0, 1,  2, 2, 1'b1, 16'h0FF0};

        rst = 1'b0;
        bit_valid = 1'b1;
        #12;
        @(negedge clk);
        chk_rst();
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("idle_bitvalid_ena", sb_ena, 0);
        bit_valid = 1'b0;

        for (int i = 0; i < 4; i++) begin
            send_bits(tbl[i].data, tbl[i].gap, tbl[i].noise);
            present(tbl[i].exp_nibs, tbl[i].st_idx, tbl[i].st_len, tbl[i].noise, (i == 0), -1);
            finish_frame(tbl[i].noise);
        end

        // asynchronous reset while presenting nibble 2, then a clean frame
        send_bits(16'h1234, 1, 1'b0);
        present(16'h1234, -1, 0, 1'b0, 1'b0, 2);
        #2 rst = 1'b0;
        #1 chk_rst();
        #1 rst = 1'b1;
        nib_ready = 1'b0;
        send_bits(16'hBEEF, 1, 1'b0);
        present(16'hBEEF, -1, 0, 1'b0, 1'b0, -1);
        finish_frame(1'b0);

`ifdef SBC_TIMEOUT_EN
        // 5 bits then 8 idle cycles: timeout pulse, back to IDLE, nothing presented
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 0; c < 13; c++) begin
            bit_valid = (c < 5);
            din = 1'b1;
            @(negedge clk);
            chk("to_err_low", err, 0);
            chk("to_busy", busy, 1);
            @(posedge clk); #1;
        end
        bit_valid = 1'b0;
        @(negedge clk);
        chk("to_err_pulse", err, 1);
        chk("to_idle", busy, 0);
        chk("to_no_valid", nib_valid, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("to_err_clear", err, 0);
        chk("to_still_no_valid", nib_valid, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
